servo_bank_ctrl: RTL and testbench



---
 rtl/servo_bank_ctrl.sv | 150 +++++++++++++++
 tb/tb_servo_bank_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/servo_bank_ctrl.sv
// servo_bank_ctrl: N-channel hobby-servo controller.
// Key codes step channel angles up/down (with auto-repeat on a held key),
// a direct-load port writes clamped angles, and an integrated PWM generator
// drives one output per channel. The pulse width of each channel is latched
// only at the last cycle of a frame, so a frame never carries a mixed pulse.
module servo_bank_ctrl #(
    parameter int NUM_CH        = 4,
    parameter int ANGLE_W       = 8,
    parameter int ANGLE_MIN     = 10,
    parameter int ANGLE_MAX     = 170,
    parameter int ANGLE_INIT    = 90,
    parameter int STEP          = 5,
    parameter int CMD_BASE      = 6,
    parameter int REPEAT_CYC    = 5_000_000,
    parameter int PERIOD_CYC    = 1_000_000,
    parameter int PULSE_BASE    = 25_000,
    parameter int PULSE_PER_DEG = 556,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,      // active-high synchronous reset
    input  logic [7:0]                key,
    input  logic                      set_valid,
    input  logic [CH_W-1:0]           set_ch,
    input  logic [ANGLE_W-1:0]        set_angle,
    output logic [NUM_CH-1:0]         pwm,
    output logic [NUM_CH*ANGLE_W-1:0] angle_o,
    output logic                      frame_start
);

    localparam int CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int REP_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
    localparam int AW1   = ANGLE_W + 1;

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PERIOD_CYC - 1);
    localparam logic [REP_W-1:0]   REP_LAST = REP_W'(REPEAT_CYC - 1);
    localparam logic [8:0]         KEY_LO   = 9'(CMD_BASE);
    localparam logic [8:0]         KEY_HI   = 9'(CMD_BASE + 2 * NUM_CH);
    localparam logic [ANGLE_W-1:0] A_MIN    = ANGLE_W'(ANGLE_MIN);
    localparam logic [ANGLE_W-1:0] A_MAX    = ANGLE_W'(ANGLE_MAX);
    localparam logic [ANGLE_W-1:0] A_INIT   = ANGLE_W'(ANGLE_INIT);
    localparam logic [ANGLE_W-1:0] A_STEP   = ANGLE_W'(STEP);
    localparam logic [AW1-1:0]     A_MAX_X  = AW1'(ANGLE_MAX);
    localparam logic [AW1-1:0]     A_STEP_X = AW1'(STEP);
    localparam logic [AW1-1:0]     A_FLOOR_X = AW1'(ANGLE_MIN + STEP);
    localparam logic [CNT_W-1:0]   CMP_INIT = CNT_W'(PULSE_BASE + ANGLE_INIT * PULSE_PER_DEG);

    logic [7:0]       key_q, key_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_start_q, frame_start_d;
    logic             key_valid, key_new, rep_hit, key_event, frame_last;

    // Key decode and auto-repeat: an event on a fresh code or every REPEAT_CYC held cycles
    always_comb begin
        key_valid = ({1'b0, key} >= KEY_LO) && ({1'b0, key} < KEY_HI);
        key_new   = (key != key_q);
        rep_hit   = (rep_cnt_q == REP_LAST);
        key_event = key_valid && (key_new || rep_hit);
        key_d     = key;
        if (!key_valid || key_new || rep_hit) begin
            rep_cnt_d = '0;
        end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
        end
    end

    // Frame counter and the frame-start strobe, which lags the counter by one cycle
    always_comb begin
        frame_last    = (cnt_q == CNT_LAST);
        cnt_d         = frame_last ? '0 : cnt_q + 1'b1;
        frame_start_d = (cnt_q == '0);
    end

    // Shared state registers
    always_ff @(posedge clk) begin
        if (rst_n) begin
            key_q         <= '0;
            rep_cnt_q     <= '0;
            cnt_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            key_q         <= key_d;
            rep_cnt_q     <= rep_cnt_d;
            cnt_q         <= cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_start = frame_start_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [7:0] KEY_INC = 8'(CMD_BASE + 2 * gi);
            localparam logic [7:0] KEY_DEC = 8'(CMD_BASE + 2 * gi + 1);

            logic [ANGLE_W-1:0] angle_q, angle_d, load_val;
            logic [AW1-1:0]     angle_x, inc_sum;
            logic [CNT_W-1:0]   cmp_q, cmp_d;
            logic               pwm_q, pwm_d;
            logic               load_hit;

            // Next angle: a direct load beats a key step on the same channel
            always_comb begin
                angle_x  = {1'b0, angle_q};
                inc_sum  = angle_x + A_STEP_X;
                load_hit = set_valid && (set_ch == CH_W'(gi));
                if (set_angle < A_MIN) begin
                    load_val = A_MIN;
                end else if (set_angle > A_MAX) begin
                    load_val = A_MAX;
                end else begin
                    load_val = set_angle;
                end
                angle_d = angle_q;
                if (load_hit) begin
                    angle_d = load_val;
                end else if (key_event && (key == KEY_INC)) begin
                    angle_d = (inc_sum > A_MAX_X) ? A_MAX : inc_sum[ANGLE_W-1:0];
                end else if (key_event && (key == KEY_DEC)) begin
                    angle_d = (angle_x < A_FLOOR_X) ? A_MIN : angle_q - A_STEP;
                end
            end

            // Compare value only moves at the frame's last cycle; pwm is the registered compare
            always_comb begin
                cmp_d = frame_last ? CNT_W'(PULSE_BASE + 32'(angle_q) * PULSE_PER_DEG) : cmp_q;
                pwm_d = (cnt_q < cmp_q);
            end

            // Per-channel state registers
            always_ff @(posedge clk) begin
                if (rst_n) begin
                    angle_q <= A_INIT;
                    cmp_q   <= CMP_INIT;
                    pwm_q   <= 1'b0;
                end else begin
                    angle_q <= angle_d;
                    cmp_q   <= cmp_d;
                    pwm_q   <= pwm_d;
                end
            end

            assign pwm[gi]                          = pwm_q;
            assign angle_o[gi*ANGLE_W +: ANGLE_W]   = angle_q;
        end
    endgenerate

endmodule

// File: tb/tb_servo_bank_ctrl.sv
// Testbench for servo_bank_ctrl: directed scenarios plus randomized key/load
// traffic. A reference model predicts angles, pwm and frame_start per cycle
// into a queue; a monitor pops and compares against the DUT outputs.
module tb_servo_bank_ctrl;

    localparam int NUM_CH   = 5;
    localparam int AW       = 8;
    localparam int AMIN     = 10;
    localparam int AMAX     = 170;
    localparam int AINIT    = 90;
    localparam int STEP     = 7;
    localparam int CMD_BASE = 6;
    localparam int REP      = 8;
    localparam int PER      = 200;
    localparam int PB       = 10;
    localparam int PPD      = 1;
    localparam int CH_W     = 3;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [7:0]             key;
    logic                   set_valid;
    logic [CH_W-1:0]        set_ch;
    logic [AW-1:0]          set_angle;
    logic [NUM_CH-1:0]      pwm;
    logic [NUM_CH*AW-1:0]   angle_o;
    logic                   frame_start;

    always #5 clk = ~clk;

    servo_bank_ctrl #(
        .NUM_CH(NUM_CH), .ANGLE_W(AW), .ANGLE_MIN(AMIN), .ANGLE_MAX(AMAX),
        .ANGLE_INIT(AINIT), .STEP(STEP), .CMD_BASE(CMD_BASE), .REPEAT_CYC(REP),
        .PERIOD_CYC(PER), .PULSE_BASE(PB), .PULSE_PER_DEG(PPD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .set_valid(set_valid),
        .set_ch(set_ch), .set_angle(set_angle), .pwm(pwm),
        .angle_o(angle_o), .frame_start(frame_start)
    );

    typedef struct {
        logic [NUM_CH*AW-1:0] ang;
        logic [NUM_CH-1:0]    pwm;
        logic                 fs;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: spec rules in plain integer arithmetic, one record per clock edge
    initial begin : model
        int   ang[NUM_CH];
        int   nv[NUM_CH];
        int   cmpv[NUM_CH];
        int   c, prev_key, hold, k, off, kch, lch, cnt, sa;
        bit   fire;
        exp_t e;
        c = 0; prev_key = 0; hold = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            ang[i] = AINIT; cmpv[i] = PB + AINIT * PPD;
        end
        forever begin
            @(posedge clk);
            if (rst_n) begin
                c = 0; prev_key = 0; hold = 0;
                for (int i = 0; i < NUM_CH; i++) begin
                    ang[i] = AINIT; cmpv[i] = PB + AINIT * PPD;
                end
                e.fs  = 1'b0;
                e.pwm = '0;
            end else begin
                k = int'(key);
                if (k >= CMD_BASE && k < CMD_BASE + 2 * NUM_CH) begin
                    hold = (k != prev_key) ? 1 : hold + 1;
                    fire = (((hold - 1) % REP) == 0);
                end else begin
                    hold = 0;
                    fire = 1'b0;
                end
                prev_key = k;
                lch = (set_valid && int'(set_ch) < NUM_CH) ? int'(set_ch) : -1;
                cnt = c % PER;
                e.fs = (cnt == 0);
                for (int i = 0; i < NUM_CH; i++) begin
                    e.pwm[i] = (cnt < cmpv[i]);
                    if (cnt == PER - 1) cmpv[i] = PB + ang[i] * PPD;
                    nv[i] = ang[i];
                end
                if (fire) begin
                    off = k - CMD_BASE;
                    kch = off / 2;
                    if (kch != lch) begin
                        if (off % 2 == 0) nv[kch] = (ang[kch] + STEP > AMAX) ? AMAX : ang[kch] + STEP;
                        else              nv[kch] = (ang[kch] - STEP < AMIN) ? AMIN : ang[kch] - STEP;
                    end
                end
                if (lch >= 0) begin
                    sa = int'(set_angle);
                    nv[lch] = (sa < AMIN) ? AMIN : ((sa > AMAX) ? AMAX : sa);
                end
                for (int i = 0; i < NUM_CH; i++) ang[i] = nv[i];
                c++;
            end
            for (int i = 0; i < NUM_CH; i++) e.ang[i*AW +: AW] = AW'(ang[i]);
            exp_q.push_back(e);
        end
    end

    // Monitor: pops one expected record per cycle and compares away from the active edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (angle_o !== e.ang) begin
                    fails++;
                    $display("FAIL angle_o t=%0t got=%h exp=%h", $time, angle_o, e.ang);
                end
                tests++;
                if (pwm !== e.pwm) begin
                    fails++;
                    $display("FAIL pwm t=%0t got=%b exp=%b", $time, pwm, e.pwm);
                end
                tests++;
                if (frame_start !== e.fs) begin
                    fails++;
                    $display("FAIL frame_start t=%0t got=%b exp=%b", $time, frame_start, e.fs);
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin : watchdog
        #(100000 * 10);
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Apply one stimulus transaction and hold it for n cycles
    task automatic drive(input int k, input bit sv, input int ch, input int a, input int n);
        key       = 8'(k);
        set_valid = sv;
        set_ch    = CH_W'(ch);
        set_angle = AW'(a);
        $display("[TB] t=%0t rst=%0b key=%0d set=%0b ch=%0d ang=%0d cycles=%0d",
                 $time, rst_n, k, sv, ch, a, n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) until frame_start is seen at a negedge
    task automatic wait_frame();
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < PER + 5) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (frame_start !== 1'b1) begin
            fails++;
            $display("FAIL frame_start_wait got=%b exp=1 after %0d cycles", frame_start, n);
        end
    endtask

    initial begin : driver
        int k, n, ch, a;
        bit sv;
        rst_n = 1'b1; key = '0; set_valid = 1'b0; set_ch = '0; set_angle = '0;
        // Reset held three cycles, then idle across more than a frame
        drive(0, 0, 0, 0, 3);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 250);
        // Held increment on ch1 for 20 cycles: three events
        drive(8, 0, 0, 0, 20);
        drive(0, 0, 0, 0, 5);
        // Upper clamp on increment, lower clamp on decrement
        drive(0, 1, 0, 168, 1);
        drive(6, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 2);
        drive(0, 1, 0, 12, 1);
        drive(7, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 2);
        // Direct load clamping and out-of-range channels
        drive(0, 1, 2, 200, 1);
        drive(0, 1, 2, 3, 1);
        drive(0, 1, 5, 100, 1);
        drive(0, 1, 7, 100, 1);
        drive(0, 0, 0, 0, 2);
        // Collisions: same channel (load wins) and different channels (both apply)
        drive(12, 1, 3, 40, 1);
        drive(0, 0, 0, 0, 1);
        drive(8, 1, 0, 50, 1);
        drive(0, 0, 0, 0, 2);
        // Mid-frame angle change, then reset mid-pulse
        wait_frame();
        drive(0, 0, 0, 0, 49);
        drive(0, 1, 1, 150, 1);
        drive(0, 0, 0, 0, 2 * PER + 10);
        wait_frame();
        drive(0, 0, 0, 0, 29);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 2);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 5);
        // Randomized traffic including invalid codes, long holds and occasional resets
        for (int it = 0; it < 150; it++) begin
            k  = ($urandom_range(0, 9) < 3) ? 0 : int'($urandom_range(0, 20));
            n  = int'($urandom_range(1, 25));
            sv = ($urandom_range(0, 9) == 0);
            ch = int'($urandom_range(0, 7));
            a  = int'($urandom_range(0, 255));
            if ($urandom_range(0, 40) == 0) begin
                rst_n = 1'b1;
                drive(k, 0, 0, 0, 2);
                rst_n = 1'b0;
            end
            drive(k, sv, ch, a, 1);
            if (n > 1) drive(k, 0, 0, 0, n - 1);
        end
        drive(0, 0, 0, 0, 3);
        tests++;
        if (exp_q.size() > 1) begin
            fails++;
            $display("FAIL scoreboard_drain got=%0d pending exp<=1", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
